// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan chain controller: host op-codes, one-hot
// FSM state encoding and a byte-count helper.
package scan_ctrl_pkg;

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  typedef logic [5:0] state_t;

  // One-hot, matching the processor control unit's state style.
  localparam logic [5:0] ST_IDLE    = 6'b000001;
  localparam logic [5:0] ST_RUN     = 6'b000010;
  localparam logic [5:0] ST_STEP    = 6'b000100;
  localparam logic [5:0] ST_SH_LOAD = 6'b001000;
  localparam logic [5:0] ST_SH_BITS = 6'b010000;
  localparam logic [5:0] ST_SH_OUT  = 6'b100000;

  function automatic int BYTES(input int chain_len);
    return (chain_len + 7) / 8;
  endfunction

endpackage

// File: rtl/scan_chain_controller_serializer.sv
// Per-byte serializer: loads a host byte, shifts b bits LSB-first into the
// chain while capturing the tail bits, then holds the captured byte for the host.
module scan_byte_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] din_i,
  input  logic [3:0] nbits_i,
  input  logic       out_ack_i,
  input  logic       scan_out_i,
  output logic       scan_enable_o,
  output logic       scan_in_o,
  output logic       dout_valid_o,
  output logic [7:0] dout_o,
  output logic       last_bit_o
);

  logic [7:0] sr_q, sr_d, cap_q, cap_d, dout_q, dout_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       se_q, se_d, si_q, si_d, dv_q, dv_d;

  assign last_bit_o    = se_q && (cnt_q == 4'd1);
  assign scan_enable_o = se_q;
  assign scan_in_o     = si_q;
  assign dout_valid_o  = dv_q;
  assign dout_o        = dout_q;

  always_comb begin
    sr_d   = sr_q;
    cap_d  = cap_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    se_d   = se_q;
    si_d   = si_q;
    dv_d   = dv_q;
    dout_d = dout_q;
    if (load_i) begin
      sr_d  = din_i;
      cap_d = 8'h00;
      cnt_d = nbits_i;
      idx_d = 3'd0;
      se_d  = (nbits_i != 4'd0);
      si_d  = din_i[0];
    end else if (se_q) begin
      // scan_out is sampled in the same cycle the head bit is presented.
      sr_d        = {1'b0, sr_q[7:1]};
      si_d        = last_bit_o ? 1'b0 : sr_q[1];
      cap_d[idx_q] = scan_out_i;
      idx_d       = idx_q + 3'd1;
      cnt_d       = cnt_q - 4'd1;
      if (last_bit_o) begin
        se_d   = 1'b0;
        dv_d   = 1'b1;
        dout_d = cap_d;
      end
    end else if (dv_q && out_ack_i) begin
      dv_d   = 1'b0;
      dout_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q   <= 8'h00;
      cap_q  <= 8'h00;
      cnt_q  <= 4'd0;
      idx_q  <= 3'd0;
      se_q   <= 1'b0;
      si_q   <= 1'b0;
      dv_q   <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      sr_q   <= sr_d;
      cap_q  <= cap_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      se_q   <= se_d;
      si_q   <= si_d;
      dv_q   <= dv_d;
      dout_q <= dout_d;
    end
  end

endmodule

// File: rtl/scan_chain_controller.sv
// Host-side scan chain driver: SHIFT exchanges the whole chain byte by byte,
// STEP/RUN gate processor_enable. RUN exists only with SCAN_CTRL_RUN_EN defined.
module scan_chain_controller
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [7:0] din,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [7:0] dout,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       processor_enable,
  input  logic       processor_halted,
  output logic       busy,
  output logic [5:0] dbg_state
);

  localparam int RW = $clog2(CHAIN_LEN + 1);

  state_t        state_q, state_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [7:0]    step_q, step_d;
  logic [3:0]    nbits;
  logic          din_hs, last_bit;

  // All three ports use valid/ready: a transfer happens on a rising edge where
  // both are high; the producer holds its payload while valid is high and not ready.
  assign cmd_ready        = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign din_ready        = (state_q == ST_SH_LOAD);
  assign busy             = (state_q != ST_IDLE);
  assign processor_enable = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign dbg_state        = state_q;
  assign din_hs           = din_valid && din_ready;
  assign nbits            = (int'(rem_q) >= 8) ? 4'd8 : 4'(rem_q);

`ifndef SCAN_CTRL_RUN_EN
  logic unused_halted;
  assign unused_halted = processor_halted;
`endif

  scan_byte_serializer u_ser (
    .clk          (clk),
    .rst          (rst),
    .load_i       (din_hs),
    .din_i        (din),
    .nbits_i      (nbits),
    .out_ack_i    (dout_ready),
    .scan_out_i   (scan_out),
    .scan_enable_o(scan_enable),
    .scan_in_o    (scan_in),
    .dout_valid_o (dout_valid),
    .dout_o       (dout),
    .last_bit_o   (last_bit)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = scan_enable ? rem_q - RW'(1) : rem_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
`ifdef SCAN_CTRL_RUN_EN
            OP_RUN:   state_d = ST_RUN;
`endif
            OP_STEP: begin
              step_d  = cmd_arg;
              state_d = (cmd_arg != 8'd0) ? ST_STEP : ST_IDLE;
            end
            OP_SHIFT: begin
              rem_d   = RW'(CHAIN_LEN);
              state_d = ST_SH_LOAD;
            end
            default:  state_d = ST_IDLE;
          endcase
        end
      end
`ifdef SCAN_CTRL_RUN_EN
      ST_RUN: begin
        if ((cmd_valid && cmd_op == OP_STOP) || processor_halted) state_d = ST_IDLE;
      end
`endif
      ST_STEP: begin
        step_d = step_q - 8'd1;
        if (step_q == 8'd1) state_d = ST_IDLE;
      end
      ST_SH_LOAD: if (din_hs) state_d = ST_SH_BITS;
      ST_SH_BITS: if (last_bit) state_d = ST_SH_OUT;
      ST_SH_OUT: begin
        if (dout_valid && dout_ready) state_d = (rem_q == '0) ? ST_IDLE : ST_SH_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      step_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_scan_chain_controller.sv
// Directed bench for scan_chain_controller with a 12-bit external chain model.
module tb_scan_chain_controller;
  import scan_ctrl_pkg::*;

  localparam int CL = 12;
  localparam logic [14:0] RST_OUTS = {7'b1000000, 8'h00};

  logic       clk, rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       din_valid, din_ready;
  logic [7:0] din;
  logic       dout_valid, dout_ready;
  logic [7:0] dout;
  logic       scan_enable, scan_in, scan_out;
  logic       processor_enable, processor_halted, busy;
  logic [5:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [CL-1:0] chain = '0;
  logic          chain_preset = 1'b0;
  int            se_total = 0;

  scan_chain_controller #(.CHAIN_LEN(CL)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .processor_enable(processor_enable), .processor_halted(processor_halted),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock/reset and external chain: head at the MSB, tail feeding scan_out.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign scan_out = chain[0];

  always @(posedge clk) begin
    if (chain_preset) chain <= 12'h3C7;
    else if (scan_enable) chain <= {scan_in, chain[CL-1:1]};
    if (scan_enable) se_total <= se_total + 1;
  end

  function automatic logic [14:0] outs();
    return {cmd_ready, din_ready, dout_valid, scan_enable, scan_in, processor_enable, busy, dout};
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic preset_chain();
    chain_preset = 1'b1;
    @(negedge clk);
    chain_preset = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++; $display("FAIL reset_hold: outs %h expected %h", outs(), RST_OUTS);
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== RST_OUTS || dbg_state !== ST_IDLE) begin
        errors++; $display("FAIL idle_outputs[%0d]: outs %h state %b expected %h state %b",
                           i, outs(), dbg_state, RST_OUTS, ST_IDLE);
      end
    end
  endtask

  task automatic test_shift(input int stall);
    logic [7:0] din_b [2];
    logic [7:0] got [2];
    logic [7:0] held;
    int nin, nout, stall_left, cyc, se_start, t_in, t_dv;
    din_b[0] = 8'hA5; din_b[1] = 8'h0F;
    got[0] = 8'h00; got[1] = 8'h00; held = 8'h00;
    nin = 0; nout = 0; stall_left = stall; cyc = 0; t_in = -1; t_dv = -1;
    preset_chain();
    se_start = se_total;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL shift_cmd_ready: got %b expected 1", cmd_ready);
    end
    send_cmd(OP_SHIFT, 8'h00);
    while (nout < BYTES(CL) && cyc < 400) begin
      din_valid  = (nin < BYTES(CL));
      din        = din_valid ? din_b[nin] : 8'h00;
      dout_ready = !(nout == 0 && stall_left > 0);
      if (dout_valid && t_dv < 0) t_dv = cyc;
      if (dout_valid && !dout_ready) begin
        checks++;
        if (scan_enable !== 1'b0) begin
          errors++; $display("FAIL stall_scan_enable: got %b expected 0", scan_enable);
        end
        if (stall_left < stall) begin
          checks++;
          if (dout !== held) begin
            errors++; $display("FAIL stall_dout_stable: got %h expected %h", dout, held);
          end
        end
        held = dout;
        stall_left--;
      end
      if (dout_valid && dout_ready) begin
        got[nout] = dout;
        nout++;
      end
      if (din_valid && din_ready) begin
        if (t_in < 0) t_in = cyc;
        nin++;
      end
      @(negedge clk);
      cyc++;
    end
    din_valid = 1'b0; din = 8'h00; dout_ready = 1'b1;
    checks++;
    if (cyc >= 400) begin
      errors++; $display("FAIL shift_timeout: %0d bytes out expected %0d", nout, BYTES(CL));
    end
    checks++;
    if (got[0] !== 8'hC7) begin
      errors++; $display("FAIL shift_dout0 (stall %0d): got %h expected c7", stall, got[0]);
    end
    checks++;
    if (got[1] !== 8'h03) begin
      errors++; $display("FAIL shift_dout1 (stall %0d): got %h expected 03", stall, got[1]);
    end
    checks++;
    if (se_total - se_start !== CL) begin
      errors++; $display("FAIL shift_enable_cycles: got %0d expected %0d", se_total - se_start, CL);
    end
    checks++;
    if (chain !== 12'hFA5) begin
      errors++; $display("FAIL shift_chain: got %h expected fa5", chain);
    end
    checks++;
    if (t_dv - t_in !== 9) begin
      errors++; $display("FAIL shift_latency: got %0d expected 9", t_dv - t_in);
    end
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++; $display("FAIL shift_end_idle: busy %b dout_valid %b expected 0 0", busy, dout_valid);
    end
  endtask

  task automatic test_step();
    send_cmd(OP_STEP, 8'd5);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (processor_enable !== (i < 5)) begin
        errors++; $display("FAIL step5_enable[%0d]: got %b expected %b", i, processor_enable, i < 5);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL step5_idle: busy %b state %b expected 0 %b", busy, dbg_state, ST_IDLE);
    end
    send_cmd(OP_STEP, 8'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (processor_enable !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL step0[%0d]: enable %b busy %b expected 0 0", i, processor_enable, busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_run();
`ifdef SCAN_CTRL_RUN_EN
    send_cmd(OP_RUN, 8'h00);
    for (int c = 1; c < 30; c++) begin
      checks++;
      if (processor_enable !== 1'b1 || scan_enable !== 1'b0) begin
        errors++; $display("FAIL run_enable[%0d]: enable %b scan_enable %b expected 1 0",
                           c, processor_enable, scan_enable);
      end
      @(negedge clk);
    end
    processor_halted = 1'b1;
    checks++;
    if (processor_enable !== 1'b1) begin
      errors++; $display("FAIL run_enable_at_halt: got %b expected 1", processor_enable);
    end
    @(negedge clk);
    processor_halted = 1'b0;
    checks++;
    if (processor_enable !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL run_halt_exit: enable %b state %b expected 0 %b",
                         processor_enable, dbg_state, ST_IDLE);
    end
    send_cmd(OP_RUN, 8'h00);
    repeat (3) @(negedge clk);
    processor_halted = 1'b1;
    send_cmd(OP_STOP, 8'h00);
    processor_halted = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dbg_state !== ST_IDLE || processor_enable !== 1'b0) begin
        errors++; $display("FAIL run_stop_halt[%0d]: state %b enable %b expected %b 0",
                           i, dbg_state, processor_enable, ST_IDLE);
      end
      @(negedge clk);
    end
`else
    send_cmd(OP_RUN, 8'h00);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dbg_state !== ST_IDLE || processor_enable !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL run_as_stop[%0d]: state %b enable %b busy %b expected %b 0 0",
                           i, dbg_state, processor_enable, busy, ST_IDLE);
      end
      @(negedge clk);
    end
`endif
  endtask

  task automatic test_reset_mid_shift();
    int se_start, cyc;
    logic saw_dv;
    preset_chain();
    se_start = se_total;
    send_cmd(OP_SHIFT, 8'h00);
    din_valid = 1'b1;
    din       = 8'hA5;
    @(negedge clk);
    din_valid = 1'b0;
    cyc = 0;
    while (se_total - se_start < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc >= 50) begin
      errors++; $display("FAIL midshift_timeout: shifted %0d expected 2", se_total - se_start);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== RST_OUTS) begin
      errors++; $display("FAIL midshift_reset_outs: outs %h expected %h", outs(), RST_OUTS);
    end
    checks++;
    if (se_total - se_start !== 3 || chain !== 12'hA78) begin
      errors++; $display("FAIL midshift_chain: bits %0d chain %h expected 3 a78",
                         se_total - se_start, chain);
    end
    rst = 1'b1;
    saw_dv = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dout_valid !== 1'b0) saw_dv = 1'b1;
    end
    checks++;
    if (saw_dv !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL midshift_no_dout: saw_dout_valid %b state %b expected 0 %b",
                         saw_dv, dbg_state, ST_IDLE);
    end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = OP_STOP; cmd_arg = 8'h00;
    din_valid = 1'b0; din = 8'h00; dout_ready = 1'b1; processor_halted = 1'b0;
    test_reset();
    test_shift(0);
    test_shift(20);
    test_step();
    test_run();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
